// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM states and op classification for the multi-cycle ALU.
// ALU_MC_DIV_EN adds DIVU/REMU to the multi-cycle op set.
package alu_mc_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_MUL   = 4'b1100;
  localparam logic [3:0] ALU_MULHU = 4'b1101;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    return op inside {ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU};
`else
    return op inside {ALU_MUL, ALU_MULHU};
`endif
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative engine: unsigned shift-add multiply, one bit per cycle.
// With ALU_MC_DIV_EN, mode=1 selects an unsigned restoring divide (lo=quotient, hi=remainder).
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] hi_q, lo_q, m_q;
  logic [DATA_WIDTH-1:0] hi_nx, lo_nx;
  logic [DATA_WIDTH:0]   acc;
  logic [CNT_W-1:0]      cnt;
  logic                  busy;

`ifdef ALU_MC_DIV_EN
  logic                  mode_q;
  logic [DATA_WIDTH:0]   shifted;
  logic                  fits;
`else
  logic                  unused_mode;
  assign unused_mode = mode;
`endif

  // done flags the final step; lo/hi expose the post-step value so the
  // caller can capture the answer on the same edge the last bit resolves.
  assign done = busy && (cnt == CNT_W'(DATA_WIDTH - 1));
  assign lo   = lo_nx;
  assign hi   = hi_nx;

  always_comb begin
    acc   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    hi_nx = acc[DATA_WIDTH:1];
    lo_nx = {acc[0], lo_q[DATA_WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    shifted = {hi_q, lo_q[DATA_WIDTH-1]};
    fits    = (shifted >= {1'b0, m_q});
    if (mode_q) begin
      hi_nx = fits ? (shifted[DATA_WIDTH-1:0] - m_q) : shifted[DATA_WIDTH-1:0];
      lo_nx = {lo_q[DATA_WIDTH-2:0], fits};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
`ifdef ALU_MC_DIV_EN
      mode_q <= 1'b0;
`endif
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      hi_q <= '0;
`ifdef ALU_MC_DIV_EN
      mode_q <= mode;
      lo_q   <= mode ? A : B;
      m_q    <= mode ? B : A;
`else
      lo_q <= B;
      m_q  <= A;
`endif
    end else if (busy) begin
      hi_q <= hi_nx;
      lo_q <= lo_nx;
      cnt  <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU behind valid/ready handshakes; single-cycle ops bypass EXEC.
// Define ALU_MC_DIV_EN to enable DIVU/REMU on the iterative engine.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  state_t                state, state_nx;
  logic                  accept, mc_start, iter_mode, iter_done;
  logic [DATA_WIDTH-1:0] iter_lo, iter_hi, res_mc, res_c;
  logic                  ovf_c, cy_c, sub_ovf;
  logic [DATA_WIDTH:0]   add_w, sub_w;
  logic [SHAMT_W-1:0]    shamt;
  logic [3:0]            op_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mc_start  = accept && is_multicycle(ALUop);
`ifdef ALU_MC_DIV_EN
  assign iter_mode = (ALUop == ALU_DIVU) || (ALUop == ALU_REMU);
`else
  assign iter_mode = 1'b0;
`endif

  alu_mc_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (mc_start),
    .mode  (iter_mode),
    .A     (A),
    .B     (B),
    .done  (iter_done),
    .lo    (iter_lo),
    .hi    (iter_hi)
  );

  always_comb begin
    shamt   = B[SHAMT_W-1:0];
    add_w   = {1'b0, A} + {1'b0, B};
    sub_w   = {1'b0, A} + {1'b0, ~B} + (DATA_WIDTH + 1)'(1);
    sub_ovf = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &&
              (sub_w[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
    res_c   = '0;
    ovf_c   = 1'b0;
    cy_c    = 1'b0;
    case (ALUop)
      ALU_AND: res_c = A & B;
      ALU_OR:  res_c = A | B;
      ALU_XOR: res_c = A ^ B;
      ALU_NOR: res_c = ~(A | B);
      ALU_ADD: begin
        res_c = add_w[DATA_WIDTH-1:0];
        cy_c  = add_w[DATA_WIDTH];
        ovf_c = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                (add_w[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
      end
      ALU_SUB: begin
        res_c = sub_w[DATA_WIDTH-1:0];
        cy_c  = ~sub_w[DATA_WIDTH];
        ovf_c = sub_ovf;
      end
      ALU_SLT: begin
        res_c = {{(DATA_WIDTH-1){1'b0}}, sub_w[DATA_WIDTH-1] ^ sub_ovf};
        ovf_c = sub_ovf;
      end
      ALU_SLTU: res_c = {{(DATA_WIDTH-1){1'b0}}, ~sub_w[DATA_WIDTH]};
      ALU_SLL:  res_c = A << shamt;
      ALU_SRL:  res_c = A >> shamt;
      ALU_SRA:  res_c = $unsigned($signed(A) >>> shamt);
      ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: res_c = '0;
      default: res_c = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      ALU_MULHU: res_mc = iter_hi;
`ifdef ALU_MC_DIV_EN
      ALU_REMU:  res_mc = iter_hi;
`endif
      default:   res_mc = iter_lo;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = is_multicycle(ALUop) ? EXEC : DONE;
      EXEC: if (iter_done) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= ALU_AND;
      Result   <= '0;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
      Zero     <= 1'b1;
    end else begin
      if (accept) begin
        op_q <= ALUop;
        if (!is_multicycle(ALUop)) begin
          Result   <= res_c;
          Overflow <= ovf_c;
          CarryOut <= cy_c;
          Zero     <= (res_c == '0);
        end
      end
      if (state == EXEC && iter_done) begin
        Result   <= res_mc;
        Overflow <= 1'b0;
        CarryOut <= 1'b0;
        Zero     <= (res_mc == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (DATA_WIDTH=32): directed cases then random ops
// checked against an arithmetic reference model; honours ALU_MC_DIV_EN.
module tb_alu_mc;

  localparam int unsigned W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  A, B, Result;
  logic [3:0]    ALUop;
  logic          Overflow, CarryOut, Zero;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  last_res;
  logic          last_ovf, last_cy;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUop     (ALUop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Overflow  (Overflow),
    .CarryOut  (CarryOut),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         o;
    logic         c;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t            e;
    longint          sa, sb, s;
    longint unsigned ua, ub, p;
    int unsigned     sh;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    sh = b % W;
    case (op)
      4'd0:  e.r = a & b;
      4'd1:  e.r = a | b;
      4'd4:  e.r = a ^ b;
      4'd5:  e.r = ~(a | b);
      4'd2: begin
        p   = ua + ub;
        e.r = p[31:0];
        e.c = p[32];
        s   = sa + sb;
        e.o = (s > MAXS) || (s < MINS);
      end
      4'd6: begin
        e.r = a - b;
        e.c = (a < b);
        s   = sa - sb;
        e.o = (s > MAXS) || (s < MINS);
      end
      4'd7: begin
        e.r = (sa < sb) ? 32'd1 : 32'd0;
        s   = sa - sb;
        e.o = (s > MAXS) || (s < MINS);
      end
      4'd3:  e.r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  e.r = a << sh;
      4'd9:  e.r = a >> sh;
      4'd10: e.r = $signed(a) >>> sh;
      4'd12: begin p = ua * ub; e.r = p[31:0];  end
      4'd13: begin p = ua * ub; e.r = p[63:32]; end
`ifdef ALU_MC_DIV_EN
      4'd14: e.r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd15: e.r = (b == 0) ? a : a % b;
`endif
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    if (op >= 4'd12 && op != 4'd11) return W + 1;
`else
    if (op == 4'd12 || op == 4'd13) return W + 1;
`endif
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit noise);
    exp_t         e;
    int           lat;
    logic [W-1:0] held;
    e   = model(op, a, b);
    lat = 0;
    while (!in_ready && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("ready_before", 64'(in_ready), 64'd1);
    A = a; B = b; ALUop = op; in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      chk("busy_ready", 64'(in_ready), 64'd0);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        A = $urandom(); B = $urandom(); ALUop = 4'($urandom());
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk($sformatf("latency op%0h", op), 64'(lat), 64'(exp_lat(op)));
    chk($sformatf("result op%0h a=%0h b=%0h", op, a, b), 64'(Result), 64'(e.r));
    chk($sformatf("ovf op%0h", op), 64'(Overflow), 64'(e.o));
    chk($sformatf("carry op%0h", op), 64'(CarryOut), 64'(e.c));
    chk($sformatf("zero op%0h", op), 64'(Zero), 64'(e.r == 0));
    held = Result;
    last_res = Result; last_ovf = Overflow; last_cy = CarryOut;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(Result), 64'(held));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("handoff_valid", 64'(out_valid), 64'd0);
    chk("handoff_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] corner [5];
    bit           saw_valid;
    corner[0] = 32'h0; corner[1] = 32'h7FFF_FFFF; corner[2] = 32'h8000_0000;
    corner[3] = 32'hFFFF_FFFF; corner[4] = 32'h1;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUop = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_ovf", 64'(Overflow), 64'd0);
    chk("rst_carry", 64'(CarryOut), 64'd0);
    chk("rst_zero", 64'(Zero), 64'd1);
    rst = 1'b0;

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 0);
    chk("add_const", 64'(last_res), 64'h8000_0000);
    chk("add_ovf_const", 64'(last_ovf), 64'd1);
    chk("add_cy_const", 64'(last_cy), 64'd0);
    run_op(4'b0110, 32'h0, 32'h1, 0, 0);
    chk("sub_const", 64'(last_res), 64'hFFFF_FFFF);
    chk("sub_borrow_const", 64'(last_cy), 64'd1);
    run_op(4'b0111, 32'h8000_0000, 32'h1, 0, 0);
    chk("slt_const", 64'(last_res), 64'd1);
    run_op(4'b0011, 32'h8000_0000, 32'h1, 0, 0);
    chk("sltu_const", 64'(last_res), 64'd0);
    run_op(4'b1010, 32'h8000_0000, 32'h0000_0024, 0, 0);
    chk("sra_const", 64'(last_res), 64'hF800_0000);
    run_op(4'b1000, 32'h1, 32'd31, 0, 0);
    chk("sll_const", 64'(last_res), 64'h8000_0000);
    run_op(4'b1100, 32'hFFFF_FFFF, 32'h2, 0, 1);
    chk("mul_const", 64'(last_res), 64'hFFFF_FFFE);
    run_op(4'b1101, 32'hFFFF_FFFF, 32'h2, 0, 1);
    chk("mulhu_const", 64'(last_res), 64'd1);
    run_op(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 5, 0);
    chk("and_const", 64'(last_res), 64'h0000_00F0);
    run_op(4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
    chk("undef_const", 64'(last_res), 64'd0);
`ifdef ALU_MC_DIV_EN
    run_op(4'b1110, 32'd100, 32'd7, 0, 0);
    chk("divu_const", 64'(last_res), 64'd14);
    run_op(4'b1111, 32'd100, 32'd7, 0, 0);
    chk("remu_const", 64'(last_res), 64'd2);
    run_op(4'b1110, 32'd55, 32'd0, 0, 0);
    chk("divu_zero_const", 64'(last_res), 64'hFFFF_FFFF);
    run_op(4'b1111, 32'd55, 32'd0, 0, 0);
    chk("remu_zero_const", 64'(last_res), 64'd55);
`endif

    // Reset on cycle 10 of a multiply must abort it without a result.
    A = 32'hDEAD_BEEF; B = 32'h1234_5678; ALUop = 4'b1100; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(Result), 64'd0);
    chk("midrst_ovf", 64'(Overflow), 64'd0);
    chk("midrst_carry", 64'(CarryOut), 64'd0);
    chk("midrst_zero", 64'(Zero), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst_no_result", 64'(saw_valid), 64'd0);
    out_ready = 1'b0;

    for (int n = 0; n < 80; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom();
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom();
      run_op(4'($urandom_range(0, 15)), ra, rb, int'($urandom_range(0, 2)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle 32-bit ALU.
- Width is generic, the opcode field is widened to 4 bits and the original codes keep their values.
- Adds XOR, NOR, SLTU, shifts and an iterative multiplier.
- Sits between the CPU decode/issue stage and writeback, behind a valid/ready handshake, so long-latency ops can stall the pipeline.

Parameters:
- DATA_WIDTH, 32: operand/result width; must be a power of 2, >= 8.
- SHAMT_W, $clog2(DATA_WIDTH): shift amount width; derived, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- A  in  DATA_WIDTH  operand A
- B  in  DATA_WIDTH  operand B; B[SHAMT_W-1:0] is the shift amount
- ALUop  in  4  operation code
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer accepts the result
- Result  out  DATA_WIDTH  registered result
- Overflow  out  1  registered signed-overflow flag
- CarryOut  out  1  registered carry/borrow flag
- Zero  out  1  registered; 1 when Result == 0

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 0011 SLTU, 0100 XOR, 0101 NOR
  - 1000 SLL, 1001 SRL, 1010 SRA, 1100 MUL (low word), 1101 MULHU (high word, unsigned)
  - 1110 DIVU and 1111 REMU exist only with the optional feature.
  - Any other code: Result 0, all flags 0, single-cycle path.
- Reset: state IDLE, in_ready=1, out_valid=0, Result=0, Overflow=0, CarryOut=0, Zero=1. Reset mid-multiply aborts the op; no result is emitted.
- FSM: IDLE -> (accept) -> EXEC -> DONE -> IDLE.
- Accept condition: in_valid && in_ready. in_ready = (state==IDLE). Operands and op are latched on accept.
- Single-cycle ops bypass EXEC: accept in cycle N, out_valid=1 in cycle N+1.
- MUL/MULHU: unsigned shift-add over a 2*DATA_WIDTH product register, one bit per cycle, DATA_WIDTH cycles in EXEC. out_valid rises DATA_WIDTH+1 cycles after accept.
- DONE holds Result and the flags stable until out_valid && out_ready, then returns to IDLE. in_ready rises the cycle after.
- There is no accept in the same cycle as the result handoff; max throughput is one op per 2 cycles.
- ADD:
  - CarryOut = carry out of the DATA_WIDTH-bit sum.
  - Overflow = operand signs equal and result sign differs.
- SUB/SLT/SLTU:
  - Computed as A + ~B + 1.
  - SUB: CarryOut = borrow (A < B unsigned).
  - SUB and SLT: Overflow = operand signs differ and result sign differs from A.
  - SLT Result = sign(diff) ^ Overflow, zero-extended; SLT CarryOut=0.
  - SLTU Result = borrow; Overflow=0, CarryOut=0.
- All other ops: Overflow=0, CarryOut=0.
- Shifts use B[SHAMT_W-1:0] only; upper bits of B are ignored. SRA replicates A's MSB.
- Zero is computed from the final Result of every op.
- in_valid while busy is ignored; the producer holds the request until in_ready.

Optional Feature:
- Macro: ALU_MC_DIV_EN.
- Defined:
  - 1110 DIVU and 1111 REMU use an unsigned restoring divider, DATA_WIDTH cycles in EXEC, same latency as MUL.
  - B==0: DIVU Result = all ones, REMU Result = A; flags 0.
- Undefined: 1110/1111 are treated as undefined codes (Result 0, single-cycle); no divider logic is synthesised.

Decomposition:
- Package alu_mc_pkg holds:
  - 4-bit opcode localparams (ALU_AND ... ALU_REMU).
  - FSM state encodings (IDLE, EXEC, DONE).
  - Helper function is_multicycle(op).
- Sub-module alu_mc_iter: shared iterative shift-add/restoring-subtract engine.
  - Ports: clk, rst, start, mode, A, B, done, lo, hi.
  - Instantiated once; the divide path sits inside an ALU_MC_DIV_EN guard.
- Single-cycle datapath stays in alu_mc.

Test Plan:
- ADD, DATA_WIDTH=32, A=0x7FFFFFFF, B=1, out_ready=1 -> one cycle later Result=0x80000000, Overflow=1, CarryOut=0, Zero=0.
- SUB A=0, B=1 -> Result=0xFFFFFFFF, CarryOut=1, Overflow=0. Then SLT A=0x80000000, B=1 -> Result=1. Then SLTU with the same operands -> Result=0.
- SRA A=0x80000000, B=0x00000024 (shamt 4) -> Result=0xF8000000. SLL A=1, B=31 -> 0x80000000.
- MUL A=0xFFFFFFFF, B=2 -> Result=0xFFFFFFFE exactly 33 cycles after accept. MULHU with the same operands -> Result=1. in_ready=0 throughout; in_valid pulses mid-op are ignored.
- Backpressure: hold out_ready=0 for 5 cycles after an AND 0xF0F0 & 0x0FF0 -> Result stays 0x00F0 and out_valid stays 1. On release, handshake completes and in_ready=1 next cycle.
- Assert rst on cycle 10 of a MUL -> outputs at reset values immediately, no out_valid. With ALU_MC_DIV_EN: DIVU 100/7 -> 14, REMU -> 2, DIVU x/0 -> 0xFFFFFFFF.
